// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader. Parses a framed byte stream
// (16-bit big-endian word count, 4*N data bytes MSB first, XOR checksum),
// writes each assembled word into instruction memory and holds the CPU
// in reset until a checksum-verified load has completed.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    // Largest legal word count; 17 bits so that ADDR_WIDTH=16 still fits.
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    state_t                state;
    state_t                state_nxt;

    logic [7:0]            len_hi;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            byte_cnt;
    logic [23:0]           asm_q;
    logic [7:0]            csum_acc;

    logic                  xfer;
    logic [15:0]           len_n;
    logic                  len_bad;
    logic                  word_last;

    logic                  load_clr;
    logic                  len_hi_en;
    logic                  len_lo_en;
    logic                  data_en;
    logic                  word_wr;

    // Status outputs are pure functions of the state, so in_ready never
    // depends combinationally on in_valid.
    assign in_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                       (state == S_DATA)   || (state == S_CSUM);
    assign cpu_hold  = (state != S_DONE);
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERROR);

    assign xfer      = in_valid && in_ready;
    assign len_n     = {len_hi, in_data};
    assign len_bad   = (len_n == 16'd0) || ({1'b0, len_n} > MAX_WORDS);
    assign word_last = (word_idx == last_idx);

    // Next-state logic and per-cycle datapath enables.
    always_comb begin
        state_nxt = state;
        load_clr  = 1'b0;
        len_hi_en = 1'b0;
        len_lo_en = 1'b0;
        data_en   = 1'b0;
        word_wr   = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    load_clr  = 1'b1;
                    state_nxt = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_hi_en = 1'b1;
                    state_nxt = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_lo_en = 1'b1;
                    state_nxt = len_bad ? S_ERROR : S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    data_en = 1'b1;
                    if (byte_cnt == 2'd3) begin
                        word_wr = 1'b1;
                        if (word_last) begin
                            state_nxt = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_nxt = (in_data == csum_acc) ? S_DONE : S_ERROR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; reset drops back to IDLE immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write port, word/byte counters and checksum accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            word_idx   <= '0;
            last_idx   <= '0;
            byte_cnt   <= 2'd0;
            csum_acc   <= 8'd0;
        end else begin
            imem_we <= word_wr;
            if (word_wr) begin
                imem_waddr <= word_idx;
                imem_wdata <= {asm_q, in_data};
            end
            if (load_clr) begin
                word_idx <= '0;
                byte_cnt <= 2'd0;
                csum_acc <= 8'd0;
            end
            if (len_lo_en) begin
                // Stored as N-1; N is bounded by 2^ADDR_WIDTH so it always fits.
                last_idx <= ADDR_WIDTH'(len_n - 16'd1);
            end
            if (data_en) begin
                byte_cnt <= byte_cnt + 2'd1;
                csum_acc <= csum_acc ^ in_data;
                if (word_wr && !word_last) begin
                    word_idx <= word_idx + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Length high byte and the first three bytes of the word in assembly.
    always_ff @(posedge clk) begin
        if (len_hi_en) begin
            len_hi <= in_data;
        end
        if (data_en) begin
            asm_q <= {asm_q[15:0], in_data};
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven, hand-written and randomized checks of
// imem_loader against a frame-level reference model.
module tb_imem_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    typedef struct {
        logic [0:10][7:0] b;
        int               nb;
        bit               d;
        bit               e;
        int               nw;
        logic [AW+31:0]   w0;
        logic [AW+31:0]   w1;
    } vec_t;

    vec_t           tbl[6];
    int             n_cmp = 0;
    int             n_fail = 0;
    logic [AW+31:0] wq[$];
    logic [AW+31:0] exp_w[$];
    logic [7:0]     cur_frame[$];
    bit             exp_d;
    bit             exp_e;

    // Record every write strobe seen by the instruction memory.
    always @(negedge clk) begin
        if (imem_we) wq.push_back({imem_waddr, imem_wdata});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax, input bit noise);
        int g;
        int k;
        g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
        for (int i = 0; i < g; i++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            start    = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) check("in_ready_wait", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Frame-level reference: parse length, rebuild words, compare checksum.
    task automatic model();
        int n;
        logic [7:0]  x;
        logic [31:0] w;
        n = int'({cur_frame[0], cur_frame[1]});
        exp_w.delete();
        if (n == 0 || n > (1 << AW)) begin
            exp_d = 1'b0;
            exp_e = 1'b1;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = {cur_frame[2+4*i], cur_frame[3+4*i], cur_frame[4+4*i], cur_frame[5+4*i]};
            x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            exp_w.push_back({AW'(i), w});
        end
        exp_d = (cur_frame[2+4*n] == x);
        exp_e = !exp_d;
    endtask

    task automatic build_frame(input int n, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        cur_frame.delete();
        cur_frame.push_back(8'(n >> 8));
        cur_frame.push_back(8'(n));
        if (n == 0 || n > (1 << AW)) return;
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            cur_frame.push_back(b);
        end
        if (corrupt) x = x ^ 8'($urandom_range(255, 1));
        cur_frame.push_back(x);
    endtask

    task automatic run_frame(input string tag, input int gapmax, input bit noise);
        wq.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " in_ready_after_start"}, in_ready, 1);
        check({tag, " hold_after_start"}, cpu_hold, 1);
        check({tag, " done_cleared"}, done, 0);
        check({tag, " error_cleared"}, error, 0);
        for (int i = 0; i < cur_frame.size(); i++) begin
            send_byte(cur_frame[i], gapmax, noise && (i >= 2));
            if (i == 1 && cur_frame.size() == 2) check({tag, " error_after_len"}, error, 1);
        end
        repeat (2) @(negedge clk);
        check({tag, " done"}, done, exp_d);
        check({tag, " error"}, error, exp_e);
        check({tag, " cpu_hold"}, cpu_hold, !exp_d);
        check({tag, " nwrites"}, wq.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wq.size(); i++) begin
            check({tag, " write"}, wq[i], exp_w[i]);
        end
    endtask

    task automatic load_vec(input int v);
        cur_frame.delete();
        for (int i = 0; i < tbl[v].nb; i++) cur_frame.push_back(tbl[v].b[i]);
        exp_w.delete();
        if (tbl[v].nw > 0) exp_w.push_back(tbl[v].w0);
        if (tbl[v].nw > 1) exp_w.push_back(tbl[v].w1);
        exp_d = tbl[v].d;
        exp_e = tbl[v].e;
    endtask

    initial begin
        tbl[0] = '{88'h00_02_20_03_00_05_AC_03_00_00_89, 11, 1'b1, 1'b0, 2,
                   {8'h00, 32'h20030005}, {8'h01, 32'hAC030000}};
        tbl[1] = '{88'h00_02_20_03_00_05_AC_03_00_00_88, 11, 1'b0, 1'b1, 2,
                   {8'h00, 32'h20030005}, {8'h01, 32'hAC030000}};
        tbl[2] = tbl[0];
        tbl[3] = '{{16'h0000, 72'h0}, 2, 1'b0, 1'b1, 0, 40'h0, 40'h0};
        tbl[4] = '{{16'h0101, 72'h0}, 2, 1'b0, 1'b1, 0, 40'h0, 40'h0};
        tbl[5] = '{{48'h0001_DEADBEEF, 8'h22, 32'h0}, 7, 1'b1, 1'b0, 1,
                   {8'h00, 32'hDEADBEEF}, 40'h0};

        // Reset behaviour
        repeat (3) @(negedge clk);
        check("rst cpu_hold", cpu_hold, 1);
        check("rst in_ready", in_ready, 0);
        check("rst imem_we", imem_we, 0);
        check("rst done", done, 0);
        check("rst error", error, 0);
        check("rst waddr", imem_waddr, 0);
        check("rst wdata", imem_wdata, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle in_ready", in_ready, 0);
            check("idle cpu_hold", cpu_hold, 1);
        end

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            load_vec(v);
            run_frame($sformatf("vec%0d", v), 0, 1'b0);
        end

        // Largest program: 256 words, last write lands on address 0xFF
        build_frame(256, 1'b0);
        model();
        run_frame("n256", 0, 1'b0);
        if (wq.size() > 0) check("n256 last_addr", wq[wq.size()-1][AW+31:32], 8'hFF);

        // Stalls with ignored start pulses during the load
        for (int r = 0; r < 3; r++) begin
            load_vec(0);
            run_frame($sformatf("stall%0d", r), 3, 1'b1);
        end

        // Randomized frames against the reference model
        for (int r = 0; r < 25; r++) begin
            int sel;
            int n;
            sel = int'($urandom_range(9, 0));
            if (sel == 0) n = 0;
            else if (sel == 1) n = 257 + int'($urandom_range(100, 0));
            else n = int'($urandom_range(8, 1));
            build_frame(n, $urandom_range(2, 0) == 0);
            model();
            run_frame($sformatf("rnd%0d", r), 2, 1'b1);
        end

        // Reset mid-load, including while a write strobe is high
        for (int nb = 5; nb <= 6; nb++) begin
            load_vec(0);
            wq.delete();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < nb; i++) send_byte(tbl[0].b[i], 0, 1'b0);
            if (nb == 6) check("midrst we_before", imem_we, 1);
            #2 reset = 1'b0;
            #1;
            check("midrst imem_we", imem_we, 0);
            check("midrst in_ready", in_ready, 0);
            check("midrst cpu_hold", cpu_hold, 1);
            check("midrst done", done, 0);
            check("midrst error", error, 0);
            check("midrst waddr", imem_waddr, 0);
            check("midrst wdata", imem_wdata, 0);
            repeat (3) @(negedge clk);
            reset = 1'b1;
            repeat (5) @(negedge clk);
            check("midrst nwrites", wq.size(), (nb == 6) ? 1 : 0);
            check("midrst idle_ready", in_ready, 0);
            load_vec(0);
            run_frame($sformatf("after_rst%0d", nb), 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
